// File: rtl/dft_bin_accum_if.sv
// Stream bundle between the DFT sequencer/multiplier and the bin accumulator,
// plus the accumulator's valid/ready result port and status flags.
interface dft_bin_accum_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  logic                     seq_valid;
  logic                     seq_last;
  logic signed [DATA_W-1:0] mul_re;
  logic signed [DATA_W-1:0] mul_im;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_re;
  logic signed [OUT_W-1:0]  out_im;
  logic                     out_sat;
  logic                     overrun;

  modport master (
    output seq_valid, seq_last, mul_re, mul_im, out_ready,
    input  out_valid, out_re, out_im, out_sat, overrun
  );

  modport slave (
    input  seq_valid, seq_last, mul_re, mul_im, out_ready,
    output out_valid, out_re, out_im, out_sat, overrun
  );
endinterface

// File: rtl/dft_bin_accum.sv
// Coherent per-frame sum of complex multiplier results into one DFT bin,
// scaled, saturated and held in a valid/ready result register.
module dft_bin_accum #(
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 16,
  parameter int SHIFT       = 10,
  parameter int MUL_LATENCY = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  dft_bin_accum_if.slave  bus
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Returns {saturated flag, clipped value} for an unscaled sum.
  function automatic logic [OUT_W:0] scale_sat_f(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] t;
    t = sum >>> SHIFT;
    if (t > SAT_MAX) begin
      scale_sat_f = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (t < SAT_MIN) begin
      scale_sat_f = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      scale_sat_f = {1'b0, t[OUT_W-1:0]};
    end
  endfunction

  logic [MUL_LATENCY-1:0]   dv_q, dv_d;
  logic [MUL_LATENCY-1:0]   dl_q, dl_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic                     first_q, first_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_re_q, out_re_d;
  logic signed [OUT_W-1:0]  out_im_q, out_im_d;
  logic                     out_sat_q, out_sat_d;
  logic                     overrun_q, overrun_d;

  logic                     d_valid_s;
  logic                     d_last_s;
  logic                     xfer_s;
  logic signed [ACC_W-1:0]  samp_re_s, samp_im_s;
  logic signed [ACC_W-1:0]  sum_re_s, sum_im_s;
  logic [OUT_W:0]           sat_re_s, sat_im_s;

  assign d_valid_s = dv_q[MUL_LATENCY-1];
  assign d_last_s  = dl_q[MUL_LATENCY-1];
  assign xfer_s    = out_valid_q & bus.out_ready;

  assign samp_re_s = {{(ACC_W-DATA_W){bus.mul_re[DATA_W-1]}}, bus.mul_re};
  assign samp_im_s = {{(ACC_W-DATA_W){bus.mul_im[DATA_W-1]}}, bus.mul_im};
  assign sum_re_s  = first_q ? samp_re_s : acc_re_q + samp_re_s;
  assign sum_im_s  = first_q ? samp_im_s : acc_im_q + samp_im_s;
  assign sat_re_s  = scale_sat_f(sum_re_s);
  assign sat_im_s  = scale_sat_f(sum_im_s);

  // Next-state: strobe delay line, accumulator and result register.
  always_comb begin
    dv_d        = {dv_q[MUL_LATENCY-2:0], bus.seq_valid};
    dl_d        = {dl_q[MUL_LATENCY-2:0], bus.seq_valid & bus.seq_last};
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_sat_d   = out_sat_q;
    overrun_d   = overrun_q;

    if (d_valid_s) begin
      acc_re_d = sum_re_s;
      acc_im_d = sum_im_s;
      first_d  = d_last_s;
    end else begin
      first_d  = first_q;
    end

    if (xfer_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // A held, unaccepted result wins over a newly completed frame.
    if (d_valid_s && d_last_s) begin
      if (out_valid_q && !bus.out_ready) begin
        overrun_d = 1'b1;
      end else begin
        out_valid_d = 1'b1;
        out_re_d    = sat_re_s[OUT_W-1:0];
        out_im_d    = sat_im_s[OUT_W-1:0];
        out_sat_d   = sat_re_s[OUT_W] | sat_im_s[OUT_W];
      end
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q        <= '0;
      dl_q        <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_sat_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      dv_q        <= dv_d;
      dl_q        <= dl_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_sat_q   <= out_sat_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.overrun   = overrun_q;

endmodule
